execution_stage: RTL and testbench
==================================

Name: execution_stage

Overview:
- EX stage of the 5-stage pipelined MIPS core.
- Consumes the ID/EX pipeline word and the MEM/WB word, resolves operand forwarding, decodes the ALU operation, executes it and registers the EX/MEM pipeline word.
- Contains ALU control, forwarding unit and ALU.

Parameters:
- none (widths fixed: 32-bit datapath, 5-bit register IDs).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IDEXReg  in  136  [31:0] instruction, [63:32] readData1, [95:64] readData2, [127:96] sign-extended immediate, [135:128] control.
- MEMWBReg  in  71  [31:0] memory result, [36:32] dest reg, [37] RegWrite, [69:38] ALU result, [70] MemToReg.
- EXMEMReg  out  75  [74] RegWrite, [73] MemWrite, [72] MemToReg, [71] MemRead, [70] overflow, [69] zero, [68:64] writeRegister, [63:32] store data (forwarded operand B), [31:0] ALU result.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low clears EXMEMReg to all zeros immediately.
- EXMEMReg loads on each rising clk edge; otherwise it holds. Latency is 1 cycle; all logic feeding it is combinational.
- Control byte bits: 0 RegWrite, 1 ALUSrc, 2 MemWrite, [4:3] ALUOp, 5 MemToReg, 6 MemRead, 7 RegDst. Examples: R-type = 0x91, lw = 0x63.
- Instruction fields: funct [5:0], shamt [10:6], rd [15:11], rt [20:16], rs [25:21].
- writeRegister = RegDst ? rd : rt.
- Forwarding selects (forwardA uses rs, forwardB uses rt), evaluated in this priority order:
  - EX/MEM hazard: EXMEMReg[74]=1, EXMEMReg[68:64]≠0 and equal to the source → select 2 (EXMEMReg[31:0]).
  - MEM/WB hazard: MEMWBReg[37]=1, dest≠0 and equal to the source → select 1 (memory result) if MemToReg=1, else select 3 (MEM/WB ALU result).
  - Otherwise select 0 (readData1 / readData2).
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- ALU operand A = forwarded A.
- ALU operand B = ALUSrc ? immediate : forwarded B.
- Store data = forwarded B (before the ALUSrc mux).
- ALU control (4-bit code):
  - ALUOp 00 → ADD; 01 → SUB; 11 → OR.
  - ALUOp 10 decodes funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL. Any other funct → ADD.
- ALU codes and operations (signed 32-bit):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
  - 0111 SLT: 1 if A<B signed, else 0.
  - 1000 SLL: B<<shamt. 1001 SRL: B>>shamt, logical.
- overflow = signed two's-complement overflow for ADD/SUB only; 0 for all other operations.
- zero = (ALU result == 0).
- Results wrap modulo 2^32.
- RegWrite, MemWrite, MemToReg and MemRead pass through unchanged.

Decomposition:
- Shared package (ex_pkg) holds:
  - ALU code constants, ALUOp encodings, funct constants;
  - forwarding-select constants;
  - bit-position constants for the IDEX, MEMWB and EXMEM word fields.
- Natural sub-module: ex_alu (operands, code, shamt → result, overflow, zero).
- ALU control and forwarding are small combinational blocks inside execution_stage.

Test Plan:
- Reset: rst_n=0 mid-run → EXMEMReg=0 immediately, with no clock edge needed. It stays 0 until rst_n=1 and the next edge.
- No forwarding:
  - Stimulus: add 0x02538820, readData1=5, readData2=10, ctrl 0x91, MEMWB RegWrite=0.
  - Result after edge: ALU result 15, writeReg 17, store 10, RegWrite 1, zero 0, overflow 0.
- EX forwarding (next cycle):
  - Stimulus: add 0x02519820, readData1=-15, readData2=7.
  - rt=17 matches EX/MEM → B=15; result 0, zero 1, writeReg 19, store 15.
- MEM forwarding on rs (EX/MEM dest ≠ 22):
  - Stimulus: or 0x02CB6825, readData2=9, MEMWB dest=22, RegWrite=1.
  - MemToReg=1, memory result=111 → result 111, writeReg 13.
  - MemToReg=0, MEM/WB ALU result=200 → result 201.
- Priority and register 0:
  - EX/MEM and MEM/WB both target rs → the EX/MEM value is used.
  - Any forwarding source with dest 0 → the register-file value is used.
- lw / sll / overflow:
  - lw 0x8E510064, ctrl 0x63, readData1=16, imm=-16 → result 0, zero 1, writeReg 17, MemRead 1, MemToReg 1, MemWrite 0.
  - sll 0x00114880, readData2=9 → result 36, writeReg 9.
  - add with 0x7FFFFFFF+1 → overflow 1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the EX stage: ALU codes, ALUOp/funct encodings,
// forwarding selects and pipeline-word field positions.
package ex_pkg;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluSll = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1001;
    localparam logic [3:0] AluNor = 4'b1100;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpOr    = 2'b11;

    localparam logic [5:0] FunctAdd = 6'h20;
    localparam logic [5:0] FunctSub = 6'h22;
    localparam logic [5:0] FunctAnd = 6'h24;
    localparam logic [5:0] FunctOr  = 6'h25;
    localparam logic [5:0] FunctNor = 6'h27;
    localparam logic [5:0] FunctSlt = 6'h2A;
    localparam logic [5:0] FunctSll = 6'h00;
    localparam logic [5:0] FunctSrl = 6'h02;

    localparam logic [1:0] FwdRegFile = 2'd0;
    localparam logic [1:0] FwdMemData = 2'd1;
    localparam logic [1:0] FwdExMem   = 2'd2;
    localparam logic [1:0] FwdWbAlu   = 2'd3;

    localparam int unsigned IdexInstrLsb = 0;
    localparam int unsigned IdexRd1Lsb   = 32;
    localparam int unsigned IdexRd2Lsb   = 64;
    localparam int unsigned IdexImmLsb   = 96;
    localparam int unsigned IdexCtrlLsb  = 128;

    localparam int unsigned CtrlRegWrite = 0;
    localparam int unsigned CtrlAluSrc   = 1;
    localparam int unsigned CtrlMemWrite = 2;
    localparam int unsigned CtrlAluOpLsb = 3;
    localparam int unsigned CtrlMemToReg = 5;
    localparam int unsigned CtrlMemRead  = 6;
    localparam int unsigned CtrlRegDst   = 7;

    localparam int unsigned MemwbMemLsb   = 0;
    localparam int unsigned MemwbDestLsb  = 32;
    localparam int unsigned MemwbRegWrite = 37;
    localparam int unsigned MemwbAluLsb   = 38;
    localparam int unsigned MemwbMemToReg = 70;

    localparam int unsigned ExmemAluLsb   = 0;
    localparam int unsigned ExmemStoreLsb = 32;
    localparam int unsigned ExmemWregLsb  = 64;
    localparam int unsigned ExmemZero     = 69;
    localparam int unsigned ExmemOverflow = 70;
    localparam int unsigned ExmemMemRead  = 71;
    localparam int unsigned ExmemMemToReg = 72;
    localparam int unsigned ExmemMemWrite = 73;
    localparam int unsigned ExmemRegWrite = 74;

    // EX/MEM beats MEM/WB; a write to register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       exmem_we,
                                           input logic [4:0] exmem_rd,
                                           input logic       memwb_we,
                                           input logic [4:0] memwb_rd,
                                           input logic       memwb_m2r);
        if (exmem_we && exmem_rd != 5'd0 && exmem_rd == src) begin
            return FwdExMem;
        end else if (memwb_we && memwb_rd != 5'd0 && memwb_rd == src) begin
            return memwb_m2r ? FwdMemData : FwdWbAlu;
        end
        return FwdRegFile;
    endfunction

endpackage

// File: rtl/ex_if.sv
// Pipeline-word bundle around the EX stage: ID/EX and MEM/WB in, EX/MEM out.
interface ex_if;
    logic [135:0] IDEXReg;
    logic [70:0]  MEMWBReg;
    logic [74:0]  EXMEMReg;

    modport master (output IDEXReg, output MEMWBReg, input EXMEMReg);
    modport slave  (input IDEXReg, input MEMWBReg, output EXMEMReg);
endinterface

// File: rtl/ex_alu.sv
// 32-bit ALU: logic ops, add/sub with signed overflow, slt and shifts by shamt.
module ex_alu
    import ex_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctrl,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero
);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_ctrl)
            AluAnd: result = a & b;
            AluOr:  result = a | b;
            AluNor: result = ~(a | b);
            AluAdd: begin
                result   = a + b;
                overflow = (a[31] == b[31]) && (result[31] != a[31]);
            end
            AluSub: begin
                result   = a - b;
                overflow = (a[31] != b[31]) && (result[31] != a[31]);
            end
            AluSlt: result = {31'd0, $signed(a) < $signed(b)};
            AluSll: result = b << shamt;
            AluSrl: result = b >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/execution_stage.sv
// EX stage of the 5-stage MIPS pipeline: forwarding, ALU control, ALU and the
// EX/MEM pipeline register.
module execution_stage
    import ex_pkg::*;
(
    input logic clk,
    input logic rst_n,
    ex_if.slave bus
);

    logic [31:0] instr, rd1, rd2, imm;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd, shamt, write_reg;
    logic [5:0]  funct;
    logic [1:0]  alu_op, fwd_a, fwd_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, fwd_b_val, op_b, alu_result;
    logic        alu_overflow, alu_zero;
    logic [74:0] exmem_d, exmem_q;
    logic        unused_opcode;

    assign instr = bus.IDEXReg[IdexInstrLsb +: 32];
    assign rd1   = bus.IDEXReg[IdexRd1Lsb +: 32];
    assign rd2   = bus.IDEXReg[IdexRd2Lsb +: 32];
    assign imm   = bus.IDEXReg[IdexImmLsb +: 32];
    assign ctrl  = bus.IDEXReg[IdexCtrlLsb +: 8];

    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];
    assign rd     = instr[15:11];
    assign rt     = instr[20:16];
    assign rs     = instr[25:21];
    assign alu_op = ctrl[CtrlAluOpLsb +: 2];

    assign unused_opcode = ^instr[31:26];

    assign write_reg = ctrl[CtrlRegDst] ? rd : rt;

    assign fwd_a = fwd_sel(rs, exmem_q[ExmemRegWrite], exmem_q[ExmemWregLsb +: 5],
                           bus.MEMWBReg[MemwbRegWrite], bus.MEMWBReg[MemwbDestLsb +: 5],
                           bus.MEMWBReg[MemwbMemToReg]);
    assign fwd_b = fwd_sel(rt, exmem_q[ExmemRegWrite], exmem_q[ExmemWregLsb +: 5],
                           bus.MEMWBReg[MemwbRegWrite], bus.MEMWBReg[MemwbDestLsb +: 5],
                           bus.MEMWBReg[MemwbMemToReg]);

    always_comb begin
        op_a = rd1;
        unique case (fwd_a)
            FwdRegFile: op_a = rd1;
            FwdMemData: op_a = bus.MEMWBReg[MemwbMemLsb +: 32];
            FwdExMem:   op_a = exmem_q[ExmemAluLsb +: 32];
            FwdWbAlu:   op_a = bus.MEMWBReg[MemwbAluLsb +: 32];
        endcase
        fwd_b_val = rd2;
        unique case (fwd_b)
            FwdRegFile: fwd_b_val = rd2;
            FwdMemData: fwd_b_val = bus.MEMWBReg[MemwbMemLsb +: 32];
            FwdExMem:   fwd_b_val = exmem_q[ExmemAluLsb +: 32];
            FwdWbAlu:   fwd_b_val = bus.MEMWBReg[MemwbAluLsb +: 32];
        endcase
    end

    // Store data is taken before the immediate mux.
    assign op_b = ctrl[CtrlAluSrc] ? imm : fwd_b_val;

    always_comb begin
        alu_ctrl = AluAdd;
        unique case (alu_op)
            AluOpAdd: alu_ctrl = AluAdd;
            AluOpSub: alu_ctrl = AluSub;
            AluOpOr:  alu_ctrl = AluOr;
            AluOpFunct: begin
                case (funct)
                    FunctAdd: alu_ctrl = AluAdd;
                    FunctSub: alu_ctrl = AluSub;
                    FunctAnd: alu_ctrl = AluAnd;
                    FunctOr:  alu_ctrl = AluOr;
                    FunctNor: alu_ctrl = AluNor;
                    FunctSlt: alu_ctrl = AluSlt;
                    FunctSll: alu_ctrl = AluSll;
                    FunctSrl: alu_ctrl = AluSrl;
                    default:  alu_ctrl = AluAdd;
                endcase
            end
        endcase
    end

    ex_alu u_alu (
        .a        (op_a),
        .b        (op_b),
        .alu_ctrl (alu_ctrl),
        .shamt    (shamt),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    assign exmem_d = {ctrl[CtrlRegWrite], ctrl[CtrlMemWrite], ctrl[CtrlMemToReg],
                      ctrl[CtrlMemRead], alu_overflow, alu_zero, write_reg,
                      fwd_b_val, alu_result};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign bus.EXMEMReg = exmem_q;

endmodule

// File: tb/tb_execution_stage.sv
// Self-checking bench for execution_stage: directed pipeline scenarios plus
// randomized instruction streams against a behavioural EX-stage model.
module tb_execution_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [74:0] exp_word;
    logic [74:0] prev_word = '0;

    ex_if bus ();

    execution_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [74:0] got, input logic [74:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [70:0] mk_memwb(input logic m2r, input logic [31:0] alu,
                                             input logic we, input logic [4:0] dest,
                                             input logic [31:0] mem);
        return {m2r, alu, we, dest, mem};
    endfunction

    // Value of a source register as seen by EX, given the older in-flight results.
    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf,
                                            input logic [70:0] memwb, input logic [74:0] prev);
        if (prev[74] && prev[68:64] != 0 && prev[68:64] == src) return prev[31:0];
        if (memwb[37] && memwb[36:32] != 0 && memwb[36:32] == src)
            return memwb[70] ? memwb[31:0] : memwb[69:38];
        return rf;
    endfunction

    function automatic logic [74:0] model(input logic [135:0] idex, input logic [70:0] memwb,
                                          input logic [74:0] prev);
        logic [31:0] ins, a, bst, b, res;
        logic [7:0]  c;
        logic [4:0]  wreg;
        longint      sa, sb, full;
        logic        ov;
        string       op;
        ins = idex[31:0];
        c   = idex[135:128];
        a   = operand(ins[25:21], idex[63:32], memwb, prev);
        bst = operand(ins[20:16], idex[95:64], memwb, prev);
        b   = c[1] ? idex[127:96] : bst;
        wreg = c[7] ? ins[15:11] : ins[20:16];
        if (c[4:3] == 2'd0) op = "add";
        else if (c[4:3] == 2'd1) op = "sub";
        else if (c[4:3] == 2'd3) op = "or";
        else begin
            case (ins[5:0])
                6'h22: op = "sub";
                6'h24: op = "and";
                6'h25: op = "or";
                6'h27: op = "nor";
                6'h2A: op = "slt";
                6'h00: op = "sll";
                6'h02: op = "srl";
                default: op = "add";
            endcase
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        res = '0;
        if (op == "add" || op == "sub") begin
            full = (op == "add") ? sa + sb : sa - sb;
            res  = 32'(full);
            ov   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        end else if (op == "and") res = a & b;
        else if (op == "or")  res = a | b;
        else if (op == "nor") res = ~(a | b);
        else if (op == "slt") res = (sa < sb) ? 32'd1 : 32'd0;
        else if (op == "sll") res = b << ins[10:6];
        else res = b >> ins[10:6];
        return {c[0], c[2], c[5], c[6], ov, res == 32'd0, wreg, bst, res};
    endfunction

    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm, input logic [7:0] ctrl,
                        input logic [70:0] memwb);
        bus.IDEXReg  = {ctrl, imm, rd2, rd1, instr};
        bus.MEMWBReg = memwb;
        exp_word = model(bus.IDEXReg, memwb, prev_word);
        @(posedge clk);
        #1;
        check_eq(tag, bus.EXMEMReg, exp_word);
        prev_word = exp_word;
    endtask

    function automatic logic [74:0] z(input logic [31:0] v);
        return {43'd0, v};
    endfunction

    logic [5:0] functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [70:0] no_wb;
        no_wb = '0;
        bus.IDEXReg  = '0;
        bus.MEMWBReg = '0;
        #12;
        check_eq("reset_state", bus.EXMEMReg, '0);
        @(negedge clk);
        rst_n = 1'b1;

        step("add_nofwd", 32'h02538820, 32'd5, 32'd10, 32'h0000_8820, 8'h91, no_wb);
        check_eq("add_res", z(bus.EXMEMReg[31:0]), z(32'd15));
        check_eq("add_wreg", z(32'(bus.EXMEMReg[68:64])), z(32'd17));
        check_eq("add_store", z(bus.EXMEMReg[63:32]), z(32'd10));
        check_eq("add_flags", z(32'(bus.EXMEMReg[74:69])), z(32'b100000));

        step("add_exfwd", 32'h02519820, 32'hFFFF_FFF1, 32'd7, 32'hFFFF_9820, 8'h91, no_wb);
        check_eq("exfwd_res_zero", z(32'(bus.EXMEMReg[69])), z(32'd1));
        check_eq("exfwd_store", z(bus.EXMEMReg[63:32]), z(32'd15));
        check_eq("exfwd_wreg", z(32'(bus.EXMEMReg[68:64])), z(32'd19));

        step("or_memfwd", 32'h02CB6825, 32'd3, 32'd9, 32'h0000_6825, 8'h91,
             mk_memwb(1'b1, 32'd200, 1'b1, 5'd22, 32'd111));
        check_eq("memfwd_res", z(bus.EXMEMReg[31:0]), z(32'd111));
        check_eq("memfwd_wreg", z(32'(bus.EXMEMReg[68:64])), z(32'd13));
        step("or_wbfwd", 32'h02CB6825, 32'h55, 32'd9, 32'h0000_6825, 8'h91,
             mk_memwb(1'b0, 32'd200, 1'b1, 5'd22, 32'd111));
        check_eq("wbfwd_res", z(bus.EXMEMReg[31:0]), z(32'd201));

        step("priority", 32'h01A02820, 32'd3, 32'd4, 32'h0000_2820, 8'h91,
             mk_memwb(1'b0, 32'd777, 1'b1, 5'd13, 32'd888));
        check_eq("priority_res", z(bus.EXMEMReg[31:0]), z(32'd205));

        step("dest0_write", 32'h00000020, 32'd1, 32'd2, 32'h20, 8'h91, no_wb);
        step("dest0_read", 32'h00000820, 32'd7, 32'd8, 32'h0820, 8'h91,
             mk_memwb(1'b0, 32'd999, 1'b1, 5'd0, 32'd999));
        check_eq("dest0_res", z(bus.EXMEMReg[31:0]), z(32'd15));

        step("lw", 32'h8E510064, 32'd16, 32'd5, 32'hFFFF_FFF0, 8'h63, no_wb);
        check_eq("lw_fields", z(32'(bus.EXMEMReg[74:64])), z(32'b101_1_0_1_10001));
        check_eq("lw_res", z(bus.EXMEMReg[31:0]), z(32'd0));

        step("bubble", 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, no_wb);
        step("sll", 32'h00114880, 32'd0, 32'd9, 32'h4880, 8'h91, no_wb);
        check_eq("sll_res", z(bus.EXMEMReg[31:0]), z(32'd36));
        check_eq("sll_wreg", z(32'(bus.EXMEMReg[68:64])), z(32'd9));

        step("add_ovf", 32'h00221820, 32'h7FFF_FFFF, 32'd1, 32'h1820, 8'h91, no_wb);
        check_eq("ovf_flag", z(32'(bus.EXMEMReg[70])), z(32'd1));

        // Asynchronous reset mid-cycle, then held across an edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", bus.EXMEMReg, '0);
        @(posedge clk);
        #1;
        check_eq("reset_hold", bus.EXMEMReg, '0);
        prev_word = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            logic [31:0] d1, d2, im;
            logic [70:0] wb;
            ins = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom),
                   ($urandom_range(0, 9) < 9) ? functs[$urandom_range(0, 7)] : 6'($urandom)};
            d1 = rand_data();
            d2 = rand_data();
            im = ($urandom_range(0, 1) == 1) ? {{16{ins[15]}}, ins[15:0]} : rand_data();
            wb = mk_memwb(1'($urandom), $urandom, 1'($urandom), 5'($urandom_range(0, 3)),
                          $urandom);
            step("random", ins, d1, d2, im, 8'($urandom), wb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
